descrambler_sync: RTL and testbench
===================================

Name: descrambler_sync

Overview:
- Sequencing and lock controller wrapped around the multiplicative descrambler in the receive path.
- Drives the descrambler's clock-enable and reset, and accepts scrambled words from the demodulator over a valid/ready handshake.
- Establishes descrambler lock by flushing the LFSR and then checking for a run of idle words.
- Forwards descrambled payload downstream only while locked; handles resync requests and loss of lock.

Parameters:
- WS, 7, bits per word; must equal the descrambler WS.
- LN, 31, descrambler LFSR length; flush length is derived from it.
- IDLE_WORD, {WS{1'b0}}, descrambled value of an idle word.
- LOCK_WORDS, 16, consecutive idle matches required to declare lock (≥1).
- CW, 8, width of the resync event counter.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset
- i_valid  in  1  scrambled word available
- o_ready  out  1  controller accepts i_word
- i_word  in  WS  scrambled word, MSB first in time
- o_dce  out  1  descrambler i_ce
- o_dreset  out  1  descrambler i_reset
- o_dword  out  WS  descrambler i_word (= i_word)
- i_dword  in  WS  descrambler o_word (registered, 1 cycle after o_dce)
- i_resync  in  1  single-cycle request to drop lock and re-hunt
- o_valid  out  1  descrambled payload valid
- i_ready  in  1  downstream accepts
- o_word  out  WS  descrambled payload
- o_locked  out  1  state == LOCKED
- o_resyncs  out  CW  saturating count of lock losses

Behaviour:
- Reset i_reset is synchronous and active-high; clock is i_clk.
- Reset values: state=HUNT, o_dreset=1 during the reset cycle, o_valid=0, o_locked=0, o_resyncs=0, all counters 0, r_pend=0.
- Combinational outputs:
  - o_dword = i_word.
  - o_dce = i_valid && o_ready && !o_dreset.
  - o_word = i_dword.
- r_pend <= o_dce. On a cycle with r_pend=1, i_dword holds the result of the previous accepted word.
- FLUSH = ceil(LN/WS); with the defaults this is 5.
- HUNT:
  - o_ready=1 (the input is drained); o_valid=0.
  - Each r_pend increments fcnt.
  - When fcnt reaches FLUSH-1 and r_pend=1: go to VERIFY and clear mcnt.
- VERIFY:
  - o_ready=1; o_valid=0.
  - r_pend && i_dword==IDLE_WORD: mcnt++. If mcnt reaches LOCK_WORDS-1, go to LOCKED.
  - r_pend && mismatch: mcnt=0 and stay in VERIFY. The LFSR is already flushed, so no descrambler reset is issued.
- LOCKED:
  - o_ready = !o_valid || i_ready.
  - o_valid <= r_pend-driven rule: set when o_dce, held while o_valid && !i_ready, cleared on acceptance with no new o_dce.
  - o_word must remain stable while o_valid && !i_ready. This is guaranteed because o_dce=0 while the output is stalled.
- Loss of lock (i_resync=1 in any state):
  - Next state HUNT; o_dreset=1 for exactly one cycle.
  - o_valid cleared; counters cleared; r_pend cleared.
  - o_resyncs++ (saturating at all-ones) only if the state was LOCKED.
  - o_dce=0 in the o_dreset cycle, so no word is consumed.
- i_resync coincident with a word handshake: the resync wins; the word is not accepted (o_ready is effectively 0).
- Words in flight on the first LOCKED cycle: the word that completed VERIFY is not forwarded. The first forwarded word is the first word accepted in LOCKED.
- Latency: one cycle from input handshake to o_valid.
- Throughput: one word per clock while i_ready=1.
- Reset mid-stream: an in-flight r_pend word is discarded; nothing is forwarded until lock is re-acquired.

Decomposition:
- Shared package sdr_sync_pkg holds:
  - state enum {HUNT, VERIFY, LOCKED};
  - the FLUSH derivation function (ceil-divide);
  - the default IDLE_WORD constant.
- One sub-module is natural: descrambler_sync_fsm (state, fcnt, mcnt, o_resyncs).
- Handshake and output-register logic stay in the top level.
- The descrambler instance lives in the parent, not inside this block.

Test Plan:
- Reset, then a scrambled all-zero idle stream with continuous i_valid -> o_dreset=1 during reset only; VERIFY entered after 5 accepted words; o_locked=1 after 5+16 words plus 1 cycle; o_valid=0 throughout.
- Locked, payload 7'h55 followed by 7'h2A scrambled, i_ready=1 -> o_word=7'h55 then 7'h2A, each exactly one cycle after acceptance; o_ready stays 1.
- Locked, i_ready=0 for 3 cycles with i_valid=1 -> o_valid held, o_word stable, o_dce=0, o_ready=0; the word is released on the cycle i_ready returns.
- In VERIFY, a single corrupted word after 10 matches -> mcnt returns to 0; lock needs 16 further matches; no o_dreset pulse.
- Locked, i_resync pulsed together with an i_valid handshake -> o_dreset=1 for one cycle, the word is not accepted, o_locked=0, o_resyncs=1; re-lock follows after 21 idle words.
- Drive 256 lock/resync cycles -> o_resyncs saturates at 8'hFF and does not wrap.

Source files
------------

// File: rtl/sdr_sync_pkg.sv
// Shared types and helpers for the descrambler sequencing/lock controller.
package sdr_sync_pkg;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } sync_state_t;

  // Fill bit of the default idle word (descrambled idle is all zeros).
  localparam logic IDLE_FILL = 1'b0;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/descrambler_sync_fsm.sv
// Lock FSM: flush counting in HUNT, idle-run counting in VERIFY, resync bookkeeping.
module descrambler_sync_fsm
  import sdr_sync_pkg::*;
#(
  parameter int unsigned FLUSH      = 5,
  parameter int unsigned LOCK_WORDS = 16,
  parameter int unsigned CW         = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_resync,
  input  logic          i_pend,
  input  logic          i_match,
  output sync_state_t   o_state,
  output logic [CW-1:0] o_resyncs
);

  localparam int unsigned FW = (FLUSH > 1) ? $clog2(FLUSH) : 1;
  localparam int unsigned MW = (LOCK_WORDS > 1) ? $clog2(LOCK_WORDS) : 1;
  localparam logic [FW-1:0] FCNT_LAST = FW'(FLUSH - 1);
  localparam logic [MW-1:0] MCNT_LAST = MW'(LOCK_WORDS - 1);

  sync_state_t   r_state, w_state_nx;
  logic [FW-1:0] r_fcnt, w_fcnt_nx;
  logic [MW-1:0] r_mcnt, w_mcnt_nx;
  logic [CW-1:0] r_resyncs, w_resyncs_nx;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= HUNT;
      r_fcnt    <= '0;
      r_mcnt    <= '0;
      r_resyncs <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_fcnt    <= w_fcnt_nx;
      r_mcnt    <= w_mcnt_nx;
      r_resyncs <= w_resyncs_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_fcnt_nx    = r_fcnt;
    w_mcnt_nx    = r_mcnt;
    w_resyncs_nx = r_resyncs;
    if (i_resync) begin
      // Resync overrides any word completing on the same cycle.
      w_state_nx = HUNT;
      w_fcnt_nx  = '0;
      w_mcnt_nx  = '0;
      if (r_state == LOCKED && r_resyncs != '1)
        w_resyncs_nx = r_resyncs + 1'b1;
    end else begin
      case (r_state)
        HUNT: begin
          if (i_pend) begin
            if (r_fcnt == FCNT_LAST) begin
              w_state_nx = VERIFY;
              w_fcnt_nx  = '0;
              w_mcnt_nx  = '0;
            end else begin
              w_fcnt_nx = r_fcnt + 1'b1;
            end
          end
        end
        VERIFY: begin
          if (i_pend) begin
            if (!i_match) begin
              w_mcnt_nx = '0;
            end else if (r_mcnt == MCNT_LAST) begin
              w_state_nx = LOCKED;
              w_mcnt_nx  = '0;
            end else begin
              w_mcnt_nx = r_mcnt + 1'b1;
            end
          end
        end
        LOCKED:  w_state_nx = LOCKED;
        default: w_state_nx = HUNT;
      endcase
    end
  end

  assign o_state   = r_state;
  assign o_resyncs = r_resyncs;

endmodule

// File: rtl/descrambler_sync.sv
// Sequencing and lock controller around the receive-path multiplicative descrambler.
module descrambler_sync
  import sdr_sync_pkg::*;
#(
  parameter int unsigned    WS         = 7,
  parameter int unsigned    LN         = 31,
  parameter logic [WS-1:0]  IDLE_WORD  = {WS{IDLE_FILL}},
  parameter int unsigned    LOCK_WORDS = 16,
  parameter int unsigned    CW         = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [WS-1:0] i_word,
  output logic          o_dce,
  output logic          o_dreset,
  output logic [WS-1:0] o_dword,
  input  logic [WS-1:0] i_dword,
  input  logic          i_resync,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [WS-1:0] o_word,
  output logic          o_locked,
  output logic [CW-1:0] o_resyncs
);

  localparam int unsigned FLUSH = ceil_div(LN, WS);

  sync_state_t w_state;
  logic        w_dreset;
  logic        w_ready;
  logic        w_dce;
  logic        r_pend;
  logic        r_valid;

  assign w_dreset = i_reset || i_resync;

  // A resync cycle also resets the descrambler, so no word may be taken then.
  always_comb begin
    w_ready = 1'b1;
    if (w_state == LOCKED)
      w_ready = !r_valid || i_ready;
    if (w_dreset)
      w_ready = 1'b0;
  end

  assign w_dce = i_valid && w_ready && !w_dreset;

  always_ff @(posedge i_clk) begin
    if (w_dreset) begin
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_pend  <= w_dce;
      r_valid <= (w_state == LOCKED) && (w_dce || (r_valid && !i_ready));
    end
  end

  descrambler_sync_fsm #(
    .FLUSH      (FLUSH),
    .LOCK_WORDS (LOCK_WORDS),
    .CW         (CW)
  ) u_fsm (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_resync  (i_resync),
    .i_pend    (r_pend),
    .i_match   (i_dword == IDLE_WORD),
    .o_state   (w_state),
    .o_resyncs (o_resyncs)
  );

  assign o_ready  = w_ready;
  assign o_dce    = w_dce;
  assign o_dreset = w_dreset;
  assign o_dword  = i_word;
  assign o_word   = i_dword;
  assign o_valid  = r_valid;
  assign o_locked = (w_state == LOCKED);

endmodule

// File: tb/tb_descrambler_sync.sv
// Randomized scoreboard bench for descrambler_sync with a behavioural descrambler attached.
module tb_descrambler_sync;

  localparam int unsigned WS    = 7;
  localparam int unsigned LN    = 31;
  localparam int unsigned LW    = 16;
  localparam int unsigned CW    = 8;
  localparam int unsigned FLUSH = (LN + WS - 1) / WS;
  localparam logic [WS-1:0] IDLE = '0;

  logic          clk = 1'b0;
  logic          i_reset, i_valid, i_resync, i_ready;
  logic [WS-1:0] i_word;
  logic          o_ready, o_dce, o_dreset, o_valid, o_locked;
  logic [WS-1:0] o_dword, o_word, d_word;
  logic [CW-1:0] o_resyncs;

  always #5 clk = ~clk;

  descrambler_sync #(
    .WS(WS), .LN(LN), .IDLE_WORD(IDLE), .LOCK_WORDS(LW), .CW(CW)
  ) dut (
    .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_word(i_word), .o_dce(o_dce), .o_dreset(o_dreset), .o_dword(o_dword),
    .i_dword(d_word), .i_resync(i_resync), .o_valid(o_valid), .i_ready(i_ready),
    .o_word(o_word), .o_locked(o_locked), .o_resyncs(o_resyncs)
  );

  // x^31 + x^28 + 1 multiplicative scrambler / descrambler, MSB first in time.
  function automatic logic [WS+30:0] scr_f(input logic [WS-1:0] d, input logic [30:0] sr);
    logic [30:0]   s;
    logic [WS-1:0] o;
    s = sr;
    for (int i = WS - 1; i >= 0; i--) begin
      o[i] = d[i] ^ s[27] ^ s[30];
      s = {s[29:0], o[i]};
    end
    return {o, s};
  endfunction

  function automatic logic [WS+30:0] descr_f(input logic [WS-1:0] w, input logic [30:0] sr);
    logic [30:0]   s;
    logic [WS-1:0] o;
    s = sr;
    for (int i = WS - 1; i >= 0; i--) begin
      o[i] = w[i] ^ s[27] ^ s[30];
      s = {s[29:0], w[i]};
    end
    return {o, s};
  endfunction

  logic [30:0] d_sr;
  always @(posedge clk) begin
    if (o_dreset) begin
      d_sr   <= '0;
      d_word <= '0;
    end else if (o_dce) begin
      {d_word, d_sr} <= descr_f(o_dword, d_sr);
    end
  end

  int unsigned   errors = 0;
  int unsigned   checks = 0;
  int unsigned   cyc = 0;
  logic [WS-1:0] exp_q[$];

  // Reference model: plaintext-level view of flush, idle run and lock.
  logic [30:0] scr_sr;
  int unsigned nflush, run, lock_cyc, resyncs_m, gap_pct;
  bit          vdone, exp_valid;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void reset_model();
    nflush   = 0;
    run      = 0;
    vdone    = 1'b0;
    lock_cyc = 32'hFFFF_FFFF;
  endfunction

  function automatic void model_accept(input logic [WS-1:0] pl);
    if (cyc >= lock_cyc) begin
      exp_q.push_back(pl);
      exp_valid = 1'b1;
    end else if (nflush < FLUSH) begin
      nflush++;
    end else if (!vdone) begin
      if (pl == IDLE) begin
        run++;
        if (run == LW) begin
          vdone    = 1'b1;
          lock_cyc = cyc + 2;
        end
      end else begin
        run = 0;
      end
    end
  endfunction

  task automatic step(input bit v, input logic [WS-1:0] pl, input bit rs, input bit rdy,
                      output bit acc);
    logic [WS-1:0] sw;
    logic [30:0]   nsr;
    bit            locked_m, exp_ready;
    {sw, nsr} = scr_f(pl, scr_sr);
    i_valid  = v;
    i_word   = v ? sw : WS'($urandom);
    i_resync = rs;
    i_ready  = rdy;
    @(negedge clk);
    locked_m  = (cyc >= lock_cyc);
    exp_ready = !rs && (!locked_m || !exp_valid || rdy);
    chk("o_ready", o_ready, exp_ready);
    chk("o_dce", o_dce, v && exp_ready);
    chk("o_dreset", o_dreset, rs);
    chk("o_locked", o_locked, locked_m);
    chk("o_valid", o_valid, exp_valid);
    chk("o_dword", o_dword, i_word);
    chk("o_resyncs", o_resyncs, resyncs_m);
    acc = v && o_ready && !rs;
    if (rs) begin
      if (locked_m && resyncs_m < 255) resyncs_m++;
      reset_model();
      exp_valid = 1'b0;
    end else begin
      if (exp_valid && rdy) exp_valid = 1'b0;
      if (acc) begin
        scr_sr = nsr;
        model_accept(pl);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [WS-1:0] pl, input int unsigned rdy_pct);
    bit          acc;
    int unsigned n;
    if ($urandom_range(99) < gap_pct)
      step(1'b0, pl, 1'b0, ($urandom_range(99) < rdy_pct), acc);
    n = 0;
    do begin
      step(1'b1, pl, 1'b0, ($urandom_range(99) < rdy_pct), acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic lock_up();
    bit          acc;
    int unsigned n;
    n = 0;
    while (!vdone && n < 200) begin
      send(IDLE, 100);
      n++;
    end
    while (cyc < lock_cyc && n < 205) begin
      step(1'b0, IDLE, 1'b0, 1'b1, acc);
      n++;
    end
    if (n >= 200) chk("lock_timeout", n, 32'd0);
  endtask

  // Scoreboard monitor: every presented word must match the head of the queue.
  always @(negedge clk) begin
    if (!i_reset && o_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'(o_word), 32'hFFFF_FFFF);
      end else begin
        chk("o_word", o_word, exp_q[0]);
        if (i_ready || i_resync) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #800_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit acc;
    scr_sr    = 31'($urandom) | 31'd1;
    resyncs_m = 0;
    exp_valid = 1'b0;
    gap_pct   = 0;
    reset_model();
    i_reset  = 1'b1;
    i_valid  = 1'b1;
    i_word   = 7'h5A;
    i_resync = 1'b0;
    i_ready  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_o_dreset", o_dreset, 1'b1);
      chk("rst_o_dce", o_dce, 1'b0);
      chk("rst_o_valid", o_valid, 1'b0);
      chk("rst_o_locked", o_locked, 1'b0);
      chk("rst_o_resyncs", o_resyncs, '0);
    end
    @(posedge clk);
    #1;
    i_reset = 1'b0;

    // Continuous idle stream to lock, then back-to-back payload.
    lock_up();
    send(7'h55, 100);
    send(7'h2A, 100);
    send(7'h11, 100);
    repeat (3) step(1'b1, 7'h22, 1'b0, 1'b0, acc);
    step(1'b1, 7'h22, 1'b0, 1'b1, acc);
    gap_pct = 20;
    repeat (40) send(WS'($urandom), 60);

    // Resync coincident with an offered word.
    step(1'b1, 7'h33, 1'b1, 1'b1, acc);

    // One corrupted word after 10 idle matches restarts the run.
    gap_pct = 0;
    repeat (FLUSH + 10) send(IDLE, 100);
    send(7'h13, 100);
    lock_up();
    repeat (10) send(WS'($urandom), 50);

    // Many lock/resync rounds: the loss counter must saturate.
    gap_pct = 10;
    repeat (258) begin
      lock_up();
      send(WS'($urandom), 70);
      step(1'($urandom), WS'($urandom), 1'b1, 1'($urandom), acc);
    end
    lock_up();
    repeat (8) send(WS'($urandom), 50);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_valid); i++)
      step(1'b0, IDLE, 1'b0, 1'b1, acc);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    chk("final_resyncs", o_resyncs, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
